// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared widths and FSM state type for the square-root unit
package sqrt_pkg;
  localparam int DATA_W = 16;
  localparam int ROOT_W = DATA_W / 2;
  localparam int SQ_W   = DATA_W + 1;

  // DONE is the only state with bit 1 set, so ready decodes from a single flop
  typedef enum logic [1:0] {
    BOOT = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/sqrt_datapath.sv
// rtl/sqrt_datapath.sv - root candidate r and its successor square s = (r+1)^2
module sqrt_datapath
  import sqrt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot,
  input  logic              wr_root,
  input  logic              wr_square,
  input  logic [DATA_W-1:0] valor,
  output logic              le,
  output logic [ROOT_W-1:0] root
);
  logic [ROOT_W-1:0] r;
  logic [SQ_W-1:0]   s;
  logic [SQ_W-1:0]   s_next;

  // (r+2)^2 = (r+1)^2 + 2r + 3, kept at full 17-bit width so 65536 is reachable
  assign s_next = s + {{(SQ_W-ROOT_W-1){1'b0}}, r, 1'b0} + SQ_W'(3);
  assign le     = (s <= {1'b0, valor});
  assign root   = r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      s <= SQ_W'(1);
    end else if (boot) begin
      r <= '0;
      s <= SQ_W'(1);
    end else begin
      if (wr_root)   r <= r + ROOT_W'(1);
      if (wr_square) s <= s_next;
    end
  end
endmodule

// File: rtl/sqrt_top.sv
// rtl/sqrt_top.sv - sequential floor(sqrt) unit: control FSM around sqrt_datapath
module sqrt_top
  import sqrt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] valor_i,
  output logic              ready_o,
  output logic [ROOT_W-1:0] root_o
);
  state_t state;
  state_t state_next;
  logic   boot;
  logic   wr_root;
  logic   wr_square;
  logic   le;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = CALC;
      CALC:    if (!le) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    boot      = (state == BOOT);
    wr_root   = (state == CALC) && le;
    wr_square = (state == CALC) && le;
  end

  assign ready_o = state[1];

  sqrt_datapath u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .boot      (boot),
    .wr_root   (wr_root),
    .wr_square (wr_square),
    .valor     (valor_i),
    .le        (le),
    .root      (root_o)
  );
endmodule

// File: tb/tb_sqrt_top.sv
// tb/tb_sqrt_top.sv - self-checking bench for sqrt_top
module tb_sqrt_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] valor_i = '0;
  logic        ready_o;
  logic [7:0]  root_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int value;
    int exp_root;
    int exp_lat;
  } vec_t;

  vec_t vecs[$];

  sqrt_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valor_i (valor_i),
    .ready_o (ready_o),
    .root_o  (root_o)
  );

  always #5 clk = ~clk;

  function automatic int ref_sqrt(input int v);
    int r;
    r = $rtoi($floor($sqrt(real'(v))));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input int v, output int root, output int lat);
    @(negedge clk);
    rst_n   = 1'b0;
    valor_i = v[15:0];
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_o) break;
    end
    root = int'(root_o);
  endtask

  initial begin
    int root, lat, v, n;
    vecs = '{
      '{0, 0, 2}, '{1, 1, 3}, '{15, 3, 5}, '{16, 4, 6}, '{17, 4, 6},
      '{65535, 255, 257}, '{65025, 255, 257}, '{65024, 254, 256},
      '{144, 12, 14}, '{255, 15, 17}, '{256, 16, 18}
    };

    #12;
    check("reset_ready", int'(ready_o), 0);
    check("reset_root", int'(root_o), 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].value, root, lat);
      check($sformatf("root(%0d)", vecs[i].value), root, vecs[i].exp_root);
      check($sformatf("latency(%0d)", vecs[i].value), lat, vecs[i].exp_lat);
    end

    // result must hold at the top of range with no wrap of r
    run_op(65535, root, lat);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check("hold_ready", int'(ready_o), 1);
      check("hold_root", int'(root_o), 255);
    end
    valor_i = 16'd9;
    repeat (3) @(posedge clk);
    #1;
    check("done_ignores_input", int'(root_o), 255);

    // asynchronous abort mid-computation
    @(negedge clk);
    rst_n   = 1'b0;
    valor_i = 16'd40000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("mid_root", int'(root_o), 49);
    check("mid_ready", int'(ready_o), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", int'(ready_o), 0);
    check("abort_root", int'(root_o), 0);
    run_op(144, root, lat);
    check("after_abort_root", root, 12);
    check("after_abort_lat", lat, 14);

    for (int i = 0; i < 150; i++) begin
      v = (i % 5 == 0) ? int'($urandom_range(60000, 65535)) : int'($urandom_range(0, 65535));
      n = ref_sqrt(v);
      run_op(v, root, lat);
      check($sformatf("rand_root(%0d)", v), root, n);
      check($sformatf("rand_lat(%0d)", v), lat, n + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
